// File: rtl/xgmii_rx_stats.sv
// XGMII receive statistics: frame delineation, per-frame length/error, running totals and per-window rates.
// Optional length-class counters are built when the macro RX_LEN_CLASS_EN is defined.
module xgmii_rx_stats #(
  parameter int TICK_CYCLES = 156250000,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_err,
  output logic [31:0] rx_frame_cnt,
  output logic [63:0] rx_byte_cnt,
  output logic [31:0] rx_err_cnt,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput
`ifdef RX_LEN_CLASS_EN
  ,
  output logic [31:0] rx_runt_cnt,
  output logic [31:0] rx_giant_cnt,
  output logic [31:0] rx_64_cnt,
  output logic [31:0] rx_1518_cnt
`endif
);

  localparam logic [7:0]  C_S   = 8'hFB;
  localparam logic [7:0]  C_T   = 8'hFD;
  localparam logic [7:0]  C_E   = 8'hFE;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam int          WIN_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TICK_CYCLES - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t      state, state_nx;
  logic [15:0] len_acc, len_acc_nx;
  logic        err_acc, err_acc_nx;
  logic        end_vld, end_err, end_good;
  logic [15:0] end_len_acc, end_len;

  logic [7:0]  t_hit, e_hit;
  logic        s0, s4, has_t, ctrl_pre_t;
  logic [3:0]  t_pos, data_all, data_lo;

  logic [WIN_W-1:0] win_cnt;
  logic             win_wrap;
  logic [31:0]      pps_acc, thr_acc, pps_base, thr_base;
  logic [32:0]      thr_sum;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Lane decode: terminate position, control chars ahead of it, data-byte counts.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise always_comb infers a latch.
    t_hit      = '0;
    e_hit      = '0;
    t_pos      = '0;
    ctrl_pre_t = 1'b0;
    data_all   = '0;
    data_lo    = '0;
    for (int k = 0; k < 8; k++) begin
      t_hit[k] = xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == C_T);
      e_hit[k] = xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == C_E);
    end
    for (int k = 7; k >= 0; k--)
      if (t_hit[k]) t_pos = 4'(k);
    for (int k = 0; k < 8; k++) begin
      if (k < int'(t_pos) && xgmii_rxc[k]) ctrl_pre_t = 1'b1;
      data_all = data_all + {3'd0, ~xgmii_rxc[k]};
      if (k < 4) data_lo = data_lo + {3'd0, ~xgmii_rxc[k]};
    end
    has_t = |t_hit;
    s0    = xgmii_rxc[0] && (xgmii_rxd[7:0]   == C_S);
    s4    = xgmii_rxc[4] && (xgmii_rxd[39:32] == C_S);
  end

  always_comb begin
    state_nx    = state;
    len_acc_nx  = len_acc;
    err_acc_nx  = err_acc;
    end_vld     = 1'b0;
    end_err     = err_acc;
    end_len_acc = len_acc;
    case (state)
      IDLE: begin
        if (s0) begin
          state_nx   = FRAME;
          len_acc_nx = 16'd7;
          err_acc_nx = 1'b0;
        end else if (s4) begin
          state_nx   = FRAME;
          len_acc_nx = 16'd3;
          err_acc_nx = 1'b0;
        end
      end
      FRAME: begin
        if (has_t) begin
          end_vld     = 1'b1;
          end_len_acc = sat_add16(len_acc, t_pos);
          end_err     = err_acc | ctrl_pre_t | (|e_hit);
          if (s4 && t_pos < 4'd4) begin
            len_acc_nx = 16'd3;
            err_acc_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else if (s0 || s4) begin
          // A start without a terminate closes the open frame as errored and reopens.
          end_vld     = 1'b1;
          end_err     = 1'b1;
          end_len_acc = s0 ? len_acc : sat_add16(len_acc, data_lo);
          len_acc_nx  = s0 ? 16'd7 : 16'd3;
          err_acc_nx  = 1'b0;
        end else begin
          len_acc_nx = sat_add16(len_acc, data_all);
          err_acc_nx = err_acc | (|xgmii_rxc);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    end_len  = (end_len_acc >= 16'd7) ? end_len_acc - 16'd7 : 16'd0;
    end_good = end_vld && !end_err && (end_len >= MIN_L) && (end_len <= MAX_L);
    win_wrap = (win_cnt == WIN_LAST);
    pps_base = win_wrap ? '0 : pps_acc;
    thr_base = win_wrap ? '0 : thr_acc;
    thr_sum  = {1'b0, thr_base} + {17'd0, end_len};
  end

  // NOTE: asynchronous active-low reset; state and counters update with non-blocking assignments only.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      len_acc <= '0;
      err_acc <= 1'b0;
    end else begin
      state   <= state_nx;
      len_acc <= len_acc_nx;
      err_acc <= err_acc_nx;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_cnt       <= '0;
      frame_valid   <= 1'b0;
      frame_len     <= '0;
      frame_err     <= 1'b0;
      rx_frame_cnt  <= '0;
      rx_byte_cnt   <= '0;
      rx_err_cnt    <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
      pps_acc       <= '0;
      thr_acc       <= '0;
    end else begin
      win_cnt     <= win_wrap ? '0 : win_cnt + 1'b1;
      frame_valid <= end_vld;
      if (end_vld) begin
        frame_len <= end_len;
        frame_err <= !end_good;
      end
      if (end_good) begin
        rx_frame_cnt <= rx_frame_cnt + 32'd1;
        rx_byte_cnt  <= rx_byte_cnt + {48'd0, end_len};
      end
      if (end_vld && !end_good) rx_err_cnt <= rx_err_cnt + 32'd1;
      if (win_wrap) begin
        rx_pps        <= pps_acc;
        rx_throughput <= thr_acc;
      end
      // A frame landing on the wrap edge is seeded into the freshly cleared window.
      pps_acc <= (end_good && pps_base != '1) ? pps_base + 32'd1 : pps_base;
      thr_acc <= !end_good ? thr_base : (thr_sum[32] ? '1 : thr_sum[31:0]);
    end
  end

`ifdef RX_LEN_CLASS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_runt_cnt  <= '0;
      rx_giant_cnt <= '0;
      rx_64_cnt    <= '0;
      rx_1518_cnt  <= '0;
    end else begin
      if (end_vld && end_len < MIN_L)       rx_runt_cnt  <= rx_runt_cnt + 32'd1;
      if (end_vld && end_len > MAX_L)       rx_giant_cnt <= rx_giant_cnt + 32'd1;
      if (end_good && end_len == 16'd64)    rx_64_cnt    <= rx_64_cnt + 32'd1;
      if (end_good && end_len == 16'd1518)  rx_1518_cnt  <= rx_1518_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_rx_stats.sv
// Directed bench for xgmii_rx_stats with a 100-cycle window; length-class checks when RX_LEN_CLASS_EN is defined.
module tb_xgmii_rx_stats;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] xgmii_rxd = {8{8'h07}};
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        frame_valid, frame_err;
  logic [15:0] frame_len;
  logic [31:0] rx_frame_cnt, rx_err_cnt, rx_pps, rx_throughput;
  logic [63:0] rx_byte_cnt;
`ifdef RX_LEN_CLASS_EN
  logic [31:0] rx_runt_cnt, rx_giant_cnt, rx_64_cnt, rx_1518_cnt;
`endif

  xgmii_rx_stats #(.TICK_CYCLES(100), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .xgmii_rxd     (xgmii_rxd),
    .xgmii_rxc     (xgmii_rxc),
    .frame_valid   (frame_valid),
    .frame_len     (frame_len),
    .frame_err     (frame_err),
    .rx_frame_cnt  (rx_frame_cnt),
    .rx_byte_cnt   (rx_byte_cnt),
    .rx_err_cnt    (rx_err_cnt),
    .rx_pps        (rx_pps),
    .rx_throughput (rx_throughput)
`ifdef RX_LEN_CLASS_EN
    ,
    .rx_runt_cnt   (rx_runt_cnt),
    .rx_giant_cnt  (rx_giant_cnt),
    .rx_64_cnt     (rx_64_cnt),
    .rx_1518_cnt   (rx_1518_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  int words = 0;
  logic [8:0]  sq[$];
  logic [15:0] len_q[$];
  logic        err_q[$];

  always @(negedge sys_clk)
    if (sys_rst_n && frame_valid) begin
      len_q.push_back(frame_len);
      err_q.push_back(frame_err);
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    @(negedge sys_clk);
    xgmii_rxc = c;
    xgmii_rxd = d;
    words++;
  endtask

  task automatic idle_words(input int n);
    repeat (n) drive(8'hFF, {8{8'h07}});
  endtask

  task automatic idle_until(input int n);
    while (words < n) drive(8'hFF, {8{8'h07}});
  endtask

  task automatic q_idle(input int n);
    repeat (n) sq.push_back({1'b1, 8'h07});
  endtask

  task automatic q_frame(input int len, input bit with_e);
    sq.push_back({1'b1, 8'hFB});
    repeat (6) sq.push_back({1'b0, 8'h55});
    sq.push_back({1'b0, 8'hD5});
    for (int i = 0; i < len; i++)
      if (with_e && i == 10) sq.push_back({1'b1, 8'hFE});
      else                   sq.push_back({1'b0, 8'(i)});
    sq.push_back({1'b1, 8'hFD});
  endtask

  task automatic q_flush();
    logic [7:0]  c;
    logic [63:0] d;
    logic [8:0]  e;
    while (sq.size() % 8 != 0) sq.push_back({1'b1, 8'h07});
    while (sq.size() > 0) begin
      for (int k = 0; k < 8; k++) begin
        e = sq.pop_front();
        c[k] = e[8];
        d[8*k +: 8] = e[7:0];
      end
      drive(c, d);
    end
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    xgmii_rxc = 8'hFF;
    xgmii_rxd = {8{8'h07}};
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    words = 0;
    len_q.delete();
    err_q.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_valid"}, 64'(frame_valid), 64'd0);
    check({pfx, "_len"},   64'(frame_len), 64'd0);
    check({pfx, "_err"},   64'(frame_err), 64'd0);
    check({pfx, "_fcnt"},  64'(rx_frame_cnt), 64'd0);
    check({pfx, "_bcnt"},  rx_byte_cnt, 64'd0);
    check({pfx, "_ecnt"},  64'(rx_err_cnt), 64'd0);
    check({pfx, "_pps"},   64'(rx_pps), 64'd0);
    check({pfx, "_thr"},   64'(rx_throughput), 64'd0);
  endtask

  initial begin
    #2;
    check_all_zero("rst");
    apply_reset();

    // Test 1: 64-byte frame from lane 0, terminate in lane 0.
    q_frame(64, 1'b0);
    q_flush();
    check("t1_not_early", 64'(frame_valid), 64'd0);
    idle_words(1);
    check("t1_valid", 64'(frame_valid), 64'd1);
    check("t1_len",   64'(frame_len), 64'd64);
    check("t1_err",   64'(frame_err), 64'd0);
    check("t1_fcnt",  64'(rx_frame_cnt), 64'd1);
    check("t1_bcnt",  rx_byte_cnt, 64'd64);
    idle_words(1);
    check("t1_pulse", 64'(frame_valid), 64'd0);

    // Test 2: lane-4 start, then a terminate in lane 2 sharing a word with the next start.
    len_q.delete(); err_q.delete();
    q_idle(4);
    q_frame(65, 1'b0);
    q_flush();
    idle_words(2);
    check("t2a_pulses", 64'(len_q.size()), 64'd1);
    check("t2a_len",    64'(len_q[0]), 64'd65);
    check("t2a_err",    64'(err_q[0]), 64'd0);
    len_q.delete(); err_q.delete();
    q_idle(4);
    q_frame(70, 1'b0);
    q_idle(1);
    q_frame(64, 1'b0);
    q_flush();
    idle_words(2);
    check("t2b_pulses", 64'(len_q.size()), 64'd2);
    check("t2b_len0",   64'(len_q[0]), 64'd70);
    check("t2b_len1",   64'(len_q[1]), 64'd64);
    check("t2b_errs",   64'(err_q[0]) + 64'(err_q[1]), 64'd0);
    check("t2_fcnt",    64'(rx_frame_cnt), 64'd4);
    check("t2_bcnt",    rx_byte_cnt, 64'd263);

    // Test 3: /E/ inside a 100-byte frame, then a 40-byte runt.
    len_q.delete(); err_q.delete();
    q_frame(100, 1'b1);
    q_flush();
    idle_words(2);
    check("t3e_err",  64'(err_q[0]), 64'd1);
    check("t3e_ecnt", 64'(rx_err_cnt), 64'd1);
    check("t3e_fcnt", 64'(rx_frame_cnt), 64'd4);
    check("t3e_bcnt", rx_byte_cnt, 64'd263);
    len_q.delete(); err_q.delete();
    q_frame(40, 1'b0);
    q_flush();
    idle_words(2);
    check("t3r_len",  64'(len_q[0]), 64'd40);
    check("t3r_err",  64'(err_q[0]), 64'd1);
    check("t3r_ecnt", 64'(rx_err_cnt), 64'd2);

    // Test 5: reset in the middle of a frame.
    drive(8'h01, {8'hD5, {6{8'h55}}, 8'hFB});
    drive(8'h00, 64'h0706050403020100);
    drive(8'h00, 64'h0F0E0D0C0B0A0908);
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("t5rst");
    apply_reset();
    q_frame(64, 1'b0);
    q_flush();
    idle_words(2);
    check("t5_fcnt", 64'(rx_frame_cnt), 64'd1);
    check("t5_bcnt", rx_byte_cnt, 64'd64);
    check("t5_ecnt", 64'(rx_err_cnt), 64'd0);

    // Test 4: five frames in window 1, a sixth whose terminate word is sampled on the wrap edge.
    apply_reset();
    repeat (5) begin
      q_frame(64, 1'b0);
      q_flush();
    end
    idle_until(89);
    q_frame(64, 1'b0);
    q_flush();
    check("t4_words",   64'(words), 64'd99);
    check("t4_pps_pre", 64'(rx_pps), 64'd0);
    idle_words(1);
    check("t4_pps1",    64'(rx_pps), 64'd5);
    check("t4_thr1",    64'(rx_throughput), 64'd320);
    check("t4_fcnt",    64'(rx_frame_cnt), 64'd6);
    idle_until(200);
    check("t4_pps2",    64'(rx_pps), 64'd1);
    check("t4_thr2",    64'(rx_throughput), 64'd64);

`ifdef RX_LEN_CLASS_EN
    // Test 6: length classes.
    apply_reset();
    q_frame(40, 1'b0);
    q_frame(64, 1'b0);
    q_frame(1518, 1'b0);
    q_frame(1600, 1'b0);
    q_flush();
    idle_words(2);
    check("t6_runt",  64'(rx_runt_cnt), 64'd1);
    check("t6_64",    64'(rx_64_cnt), 64'd1);
    check("t6_1518",  64'(rx_1518_cnt), 64'd1);
    check("t6_giant", 64'(rx_giant_cnt), 64'd1);
    check("t6_ecnt",  64'(rx_err_cnt), 64'd2);
    check("t6_fcnt",  64'(rx_frame_cnt), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
